// File: rtl/pe_row_acc.sv
// pe_row_acc: N-lane signed dot product against a held weight register,
// accumulated over a programmable number of beats, then scaled by exp_bias,
// offset by psum and saturated to OUT_W bits. One beat per cycle, no stall.
module pe_row_acc #(
    parameter int N       = 4,
    parameter int IMG_W   = 8,
    parameter int WGT_W   = 8,
    parameter int OUT_W   = 16,
    parameter int SHIFT_W = 5,
    parameter int CNT_W   = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    wgt_load,
    input  logic [N*WGT_W-1:0]      wgt,
    input  logic                    in_valid,
    input  logic [N*IMG_W-1:0]      img,
    input  logic [SHIFT_W-1:0]      exp_bias,
    input  logic signed [OUT_W-1:0] psum,
    input  logic [CNT_W-1:0]        acc_len,
    input  logic                    acc_clr,
    output logic                    out_valid,
    output logic signed [OUT_W-1:0] out,
    output logic                    sat
);
    localparam int P_W   = IMG_W + WGT_W;
    localparam int SUM_W = P_W + $clog2(N);
    localparam int ACC_W = SUM_W + CNT_W;
    localparam int R_W   = ACC_W + 1;

    localparam logic signed [R_W-1:0] MAX_R = {{(R_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
    localparam logic signed [R_W-1:0] MIN_R = {{(R_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

    // acc_len of 0 behaves as a single-beat group
    function automatic logic [CNT_W-1:0] eff_len(input logic [CNT_W-1:0] l);
        return (l == '0) ? CNT_W'(1) : l;
    endfunction

    // Returns {clipped, value} with value clamped to the signed OUT_W range
    function automatic logic [OUT_W:0] sat_clip(input logic signed [R_W-1:0] r);
        if (r > MAX_R) return {1'b1, MAX_R[OUT_W-1:0]};
        if (r < MIN_R) return {1'b1, MIN_R[OUT_W-1:0]};
        return {1'b0, r[OUT_W-1:0]};
    endfunction

    logic [N*WGT_W-1:0]      wgt_q;

    logic                    vld_p1_q;
    logic signed [P_W-1:0]   prod_p1_d [N];
    logic signed [P_W-1:0]   prod_p1_q [N];
    logic [SHIFT_W-1:0]      exp_p1_q;
    logic signed [OUT_W-1:0] psum_p1_q;
    logic [CNT_W-1:0]        len_p1_q;

    logic                    vld_p2_q;
    logic signed [SUM_W-1:0] sum_p2_d;
    logic signed [SUM_W-1:0] sum_p2_q;
    logic [SHIFT_W-1:0]      exp_p2_q;
    logic signed [OUT_W-1:0] psum_p2_q;
    logic [CNT_W-1:0]        len_p2_q;

    logic signed [ACC_W-1:0] acc_d, acc_q, acc_new;
    logic [CNT_W-1:0]        cnt_d, cnt_q;
    logic [CNT_W-1:0]        len_d, len_q, len_cur;
    logic                    last;
    logic                    fin_p3_d, fin_p3_q;
    logic [SHIFT_W-1:0]      exp_p3_q;
    logic signed [OUT_W-1:0] psum_p3_q;

    logic signed [ACC_W-1:0] sh_p3;
    logic signed [R_W-1:0]   r_p3;
    logic                    clip_sat;
    logic signed [OUT_W-1:0] clip_val;
    logic signed [OUT_W-1:0] out_d, out_q;
    logic                    out_valid_q, sat_d, sat_q;

    // Weight register; a same-cycle beat still sees the old weights
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)          wgt_q <= '0;
        else if (wgt_load) wgt_q <= wgt;
    end

    // ---- S1: per-lane signed products ----
    // Lane multipliers, operands sign-extended to the full product width
    always_comb begin
        for (int i = 0; i < N; i++) begin
            prod_p1_d[i] = P_W'($signed(img[i*IMG_W +: IMG_W]))
                         * P_W'($signed(wgt_q[i*WGT_W +: WGT_W]));
        end
    end

    // ---- S2: add tree ----
    // Sum of lane products, sign-extended to SUM_W
    always_comb begin
        sum_p2_d = '0;
        for (int i = 0; i < N; i++) begin
            sum_p2_d = sum_p2_d + SUM_W'(prod_p1_q[i]);
        end
    end

    // ---- S3: accumulate ----
    // Group bookkeeping; the group length is taken from the group's first beat
    always_comb begin
        len_cur  = (cnt_q == '0) ? len_p2_q : len_q;
        last     = (cnt_q == len_cur - CNT_W'(1));
        acc_new  = (cnt_q == '0) ? ACC_W'(sum_p2_q) : acc_q + ACC_W'(sum_p2_q);
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        len_d    = len_q;
        fin_p3_d = 1'b0;
        if (acc_clr) begin
            acc_d = '0;
            cnt_d = '0;
        end else if (vld_p2_q) begin
            acc_d    = acc_new;
            fin_p3_d = last;
            if (cnt_q == '0) len_d = len_p2_q;
            cnt_d    = last ? '0 : cnt_q + CNT_W'(1);
        end
    end

    // ---- Output: scale, offset, saturate ----
    // Finalise from the accumulator left by the last beat of a group
    always_comb begin
        sh_p3                = acc_q >>> exp_p3_q;
        r_p3                 = R_W'(sh_p3) + R_W'(psum_p3_q);
        {clip_sat, clip_val} = sat_clip(r_p3);
        out_d                = fin_p3_q ? clip_val : out_q;
        sat_d                = fin_p3_q & clip_sat;
    end

    // Control state: valids, accumulator, counter and the output registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            vld_p1_q    <= 1'b0;
            vld_p2_q    <= 1'b0;
            fin_p3_q    <= 1'b0;
            acc_q       <= '0;
            cnt_q       <= '0;
            len_q       <= '0;
            out_q       <= '0;
            out_valid_q <= 1'b0;
            sat_q       <= 1'b0;
        end else begin
            vld_p1_q    <= in_valid;
            vld_p2_q    <= vld_p1_q & ~acc_clr;
            fin_p3_q    <= fin_p3_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            len_q       <= len_d;
            out_q       <= out_d;
            out_valid_q <= fin_p3_q;
            sat_q       <= sat_d;
        end
    end

    // Free-running datapath registers; qualified by the valids above
    always_ff @(posedge clk) begin
        prod_p1_q <= prod_p1_d;
        exp_p1_q  <= exp_bias;
        psum_p1_q <= psum;
        len_p1_q  <= eff_len(acc_len);
        sum_p2_q  <= sum_p2_d;
        exp_p2_q  <= exp_p1_q;
        psum_p2_q <= psum_p1_q;
        len_p2_q  <= len_p1_q;
        exp_p3_q  <= exp_p2_q;
        psum_p3_q <= psum_p2_q;
    end

    assign out_valid = out_valid_q;
    assign out       = out_q;
    assign sat       = sat_q;
endmodule

// File: tb/tb_pe_row_acc.sv
module tb_pe_row_acc;
    logic              clk;
    logic              rst;
    logic              wgt_load;
    logic [31:0]       wgt;
    logic              in_valid;
    logic [31:0]       img;
    logic [4:0]        exp_bias;
    logic signed [15:0] psum;
    logic [7:0]        acc_len;
    logic              acc_clr;
    logic              out_valid;
    logic signed [15:0] out;
    logic              sat;

    int passed = 0;
    int total  = 0;
    int strobes = 0;
    logic signed [15:0] out_log[$];
    logic               sat_log[$];

    pe_row_acc #(.N(4), .IMG_W(8), .WGT_W(8), .OUT_W(16), .SHIFT_W(5), .CNT_W(8)) dut (
        .clk(clk), .rst(rst), .wgt_load(wgt_load), .wgt(wgt), .in_valid(in_valid),
        .img(img), .exp_bias(exp_bias), .psum(psum), .acc_len(acc_len),
        .acc_clr(acc_clr), .out_valid(out_valid), .out(out), .sat(sat)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Record every result strobe, sampled mid-cycle
    always @(negedge clk) begin
        if (out_valid === 1'b1) begin
            strobes = strobes + 1;
            out_log.push_back(out);
            sat_log.push_back(sat);
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) step();
    endtask

    task automatic set_w(input logic [7:0] w);
        wgt_load = 1'b1;
        wgt      = {4{w}};
        step();
        wgt_load = 1'b0;
    endtask

    task automatic beat(input logic [7:0] im, input logic [7:0] len,
                        input logic [4:0] e, input logic signed [15:0] ps);
        in_valid = 1'b1;
        img      = {4{im}};
        acc_len  = len;
        exp_bias = e;
        psum     = ps;
        step();
        in_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst      = 1'b0;
        wgt_load = 1'($urandom);
        wgt      = $urandom;
        in_valid = 1'($urandom);
        img      = $urandom;
        exp_bias = 5'($urandom);
        psum     = 16'($urandom);
        acc_len  = 8'($urandom);
        acc_clr  = 1'($urandom);
        #3;
        repeat (3) @(posedge clk);
        #1;
        total++; if (out !== 16'sd0) $display("FAIL reset_out got %0d want 0", out); else passed++;
        total++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid got %0b want 0", out_valid); else passed++;
        total++; if (sat !== 1'b0) $display("FAIL reset_sat got %0b want 0", sat); else passed++;
        wgt_load = 1'b0; in_valid = 1'b0; acc_clr = 1'b0; img = '0; wgt = '0;
        exp_bias = '0; psum = '0; acc_len = 8'd1;
        rst = 1'b1;
        idle(6);
        total++; if (strobes !== 0) $display("FAIL reset_idle strobes got %0d want 0", strobes); else passed++;
    endtask

    task automatic test_basic();
        int base;
        set_w(8'd1);
        base = strobes;
        beat(8'd15, 8'd1, 5'd0, 16'sd0);
        @(negedge clk);
        total++; if (out_valid !== 1'b0) $display("FAIL lat_t0 out_valid got %0b want 0", out_valid); else passed++;
        step(); @(negedge clk);
        total++; if (out_valid !== 1'b0) $display("FAIL lat_t1 out_valid got %0b want 0", out_valid); else passed++;
        step(); @(negedge clk);
        total++; if (out_valid !== 1'b0) $display("FAIL lat_t2 out_valid got %0b want 0", out_valid); else passed++;
        step(); @(negedge clk);
        total++; if (out_valid !== 1'b1) $display("FAIL lat_t3 out_valid got %0b want 1", out_valid); else passed++;
        total++; if (out !== 16'sd60) $display("FAIL basic_60 out got %0d want 60", out); else passed++;
        total++; if (sat !== 1'b0) $display("FAIL basic_60 sat got %0b want 0", sat); else passed++;
        step(); @(negedge clk);
        total++; if (out_valid !== 1'b0) $display("FAIL strobe_width out_valid got %0b want 0", out_valid); else passed++;
        total++; if (out !== 16'sd60) $display("FAIL out_hold got %0d want 60", out); else passed++;
        step();
        beat(8'd7, 8'd1, 5'd1, 16'sd15);
        idle(5);
        total++; if (strobes !== base + 2) $display("FAIL basic_29 strobes got %0d want %0d", strobes, base + 2); else passed++;
        total++; if (out_log[base+1] !== 16'sd29) $display("FAIL basic_29 out got %0d want 29", out_log[base+1]); else passed++;
        set_w(8'hFF);
        beat(8'd7, 8'd1, 5'd0, 16'sd0);
        idle(5);
        total++; if (out_log[base+2] !== -16'sd28) $display("FAIL neg_wgt out got %0d want -28", out_log[base+2]); else passed++;
        beat(8'd7, 8'd1, 5'd1, -16'sd3);
        idle(5);
        total++; if (out_log[base+3] !== -16'sd17) $display("FAIL neg_shift out got %0d want -17", out_log[base+3]); else passed++;
    endtask

    task automatic test_acc_sat();
        int base;
        set_w(8'd127);
        base = strobes;
        for (int i = 0; i < 4; i++) beat(8'd127, 8'd4, 5'd0, 16'sd0);
        idle(6);
        total++; if (strobes !== base + 1) $display("FAIL acc4 strobes got %0d want %0d", strobes, base + 1); else passed++;
        total++; if (out_log[base] !== 16'sd32767) $display("FAIL acc4_sat out got %0d want 32767", out_log[base]); else passed++;
        total++; if (sat_log[base] !== 1'b1) $display("FAIL acc4_sat sat got %0b want 1", sat_log[base]); else passed++;
        for (int i = 0; i < 4; i++) beat(8'd127, 8'd4, 5'd4, 16'sd0);
        idle(6);
        total++; if (strobes !== base + 2) $display("FAIL acc4_shift strobes got %0d want %0d", strobes, base + 2); else passed++;
        total++; if (out_log[base+1] !== 16'sd16129) $display("FAIL acc4_shift out got %0d want 16129", out_log[base+1]); else passed++;
        total++; if (sat_log[base+1] !== 1'b0) $display("FAIL acc4_shift sat got %0b want 0", sat_log[base+1]); else passed++;
        set_w(8'd1);
        beat(8'd15, 8'd0, 5'd0, 16'sd0);
        idle(5);
        total++; if (strobes !== base + 3) $display("FAIL len0 strobes got %0d want %0d", strobes, base + 3); else passed++;
        total++; if (out_log[base+2] !== 16'sd60) $display("FAIL len0 out got %0d want 60", out_log[base+2]); else passed++;
        set_w(8'h80);
        beat(8'd127, 8'd1, 5'd0, 16'sd0);
        idle(5);
        total++; if (out_log[base+3] !== -16'sd32768) $display("FAIL neg_sat out got %0d want -32768", out_log[base+3]); else passed++;
        total++; if (sat_log[base+3] !== 1'b1) $display("FAIL neg_sat sat got %0b want 1", sat_log[base+3]); else passed++;
    endtask

    task automatic test_weight_timing();
        int base;
        set_w(8'd1);
        base     = strobes;
        in_valid = 1'b1;
        img      = {4{8'd15}};
        acc_len  = 8'd1;
        exp_bias = 5'd0;
        psum     = 16'sd0;
        wgt_load = 1'b1;
        wgt      = {4{8'd2}};
        step();
        wgt_load = 1'b0;
        step();
        in_valid = 1'b0;
        idle(5);
        total++; if (strobes !== base + 2) $display("FAIL wgt_timing strobes got %0d want %0d", strobes, base + 2); else passed++;
        total++; if (out_log[base] !== 16'sd60) $display("FAIL wgt_old out got %0d want 60", out_log[base]); else passed++;
        total++; if (out_log[base+1] !== 16'sd120) $display("FAIL wgt_new out got %0d want 120", out_log[base+1]); else passed++;
    endtask

    task automatic test_back_to_back();
        int base;
        logic [8:0] pat;
        pat = 9'b111100101;
        set_w(8'd1);
        base = strobes;
        for (int i = 0; i < 9; i++) begin
            in_valid = pat[i];
            img      = {4{8'd1}};
            acc_len  = 8'd3;
            exp_bias = 5'd0;
            psum     = 16'sd0;
            step();
        end
        in_valid = 1'b0;
        idle(6);
        total++; if (strobes !== base + 2) $display("FAIL bubbles strobes got %0d want %0d", strobes, base + 2); else passed++;
        total++; if (out_log[base] !== 16'sd12) $display("FAIL bubbles_g1 out got %0d want 12", out_log[base]); else passed++;
        total++; if (out_log[base+1] !== 16'sd12) $display("FAIL bubbles_g2 out got %0d want 12", out_log[base+1]); else passed++;
        beat(8'd1, 8'd2, 5'd0, 16'sd0);
        beat(8'd1, 8'd1, 5'd0, 16'sd0);
        idle(5);
        total++; if (strobes !== base + 3) $display("FAIL len_change strobes got %0d want %0d", strobes, base + 3); else passed++;
        total++; if (out_log[base+2] !== 16'sd8) $display("FAIL len_change out got %0d want 8", out_log[base+2]); else passed++;
    endtask

    task automatic test_abort();
        int base;
        set_w(8'd1);
        base = strobes;
        beat(8'd1, 8'd4, 5'd0, 16'sd0);
        beat(8'd1, 8'd4, 5'd0, 16'sd0);
        acc_clr  = 1'b1;
        in_valid = 1'b1;
        step();
        acc_clr  = 1'b0;
        in_valid = 1'b0;
        beat(8'd1, 8'd4, 5'd0, 16'sd0);
        beat(8'd1, 8'd4, 5'd0, 16'sd0);
        idle(6);
        total++; if (strobes !== base) $display("FAIL abort_early strobes got %0d want %0d", strobes, base); else passed++;
        beat(8'd1, 8'd4, 5'd0, 16'sd0);
        idle(6);
        total++; if (strobes !== base + 1) $display("FAIL abort_done strobes got %0d want %0d", strobes, base + 1); else passed++;
        total++; if (out_log[base] !== 16'sd16) $display("FAIL abort_done out got %0d want 16", out_log[base]); else passed++;
    endtask

    task automatic test_reset_mid_group();
        int base;
        set_w(8'd1);
        base = strobes;
        beat(8'd1, 8'd2, 5'd0, 16'sd0);
        rst = 1'b0;
        #2;
        rst = 1'b1;
        idle(6);
        total++; if (strobes !== base) $display("FAIL rst_mid strobes got %0d want %0d", strobes, base); else passed++;
        beat(8'd15, 8'd1, 5'd0, 16'sd0);
        idle(5);
        total++; if (strobes !== base + 1) $display("FAIL rst_wgt strobes got %0d want %0d", strobes, base + 1); else passed++;
        total++; if (out_log[base] !== 16'sd0) $display("FAIL rst_wgt out got %0d want 0", out_log[base]); else passed++;
        set_w(8'd1);
        beat(8'd1, 8'd2, 5'd0, 16'sd0);
        idle(5);
        total++; if (strobes !== base + 1) $display("FAIL rst_cnt strobes got %0d want %0d", strobes, base + 1); else passed++;
        beat(8'd1, 8'd2, 5'd0, 16'sd0);
        idle(5);
        total++; if (strobes !== base + 2) $display("FAIL rst_group strobes got %0d want %0d", strobes, base + 2); else passed++;
        total++; if (out_log[base+1] !== 16'sd8) $display("FAIL rst_group out got %0d want 8", out_log[base+1]); else passed++;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_acc_sat();
        test_weight_timing();
        test_back_to_back();
        test_abort();
        test_reset_mid_group();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/pe_row_acc.md
# pe_row_acc

Parametrised successor to the 4-lane SD4 processing-element row. It computes an N-lane signed dot product of image and weight lanes against a locally held weight register. It can accumulate a programmable number of consecutive dot products before scaling by `exp_bias`, adding `psum`, saturating and emitting one result. It sits between the activation/weight buffers and the partial-sum chain of the MAC array, fully pipelined at one input beat per cycle.

## Interface
Parameters:
- `N`, 4, number of lanes
- `IMG_W`, 8, signed image lane width
- `WGT_W`, 8, signed weight lane width
- `OUT_W`, 16, signed output / psum width
- `SHIFT_W`, 5, width of `exp_bias`
- `CNT_W`, 8, width of `acc_len`

Ports:
- `clk`  in  1  single clock, all state on rising edge
- `rst`  in  1  asynchronous, active-low reset
- `wgt_load`  in  1  latch `wgt` into weight register
- `wgt`  in  N*WGT_W  weight lanes, lane i at bits [i*WGT_W +: WGT_W]
- `in_valid`  in  1  input beat valid
- `img`  in  N*IMG_W  image lanes, same packing as `wgt`
- `exp_bias`  in  SHIFT_W  arithmetic right-shift amount, unsigned
- `psum`  in  OUT_W  signed partial sum added to the result
- `acc_len`  in  CNT_W  beats per accumulation group; 0 is treated as 1
- `acc_clr`  in  1  synchronous abort of the current group
- `out_valid`  out  1  one-cycle result strobe
- `out`  out  OUT_W  signed saturated result
- `sat`  out  1  result was clipped; valid with `out_valid`

## Operation
- **Weight register:**
  - `wgt_load`=1 latches `wgt` at the clock edge.
  - A beat presented with `in_valid` in the same cycle uses the previous weights.
  - Weights persist until the next load.
- **S1 (multiply):** registers `p_i = img_i * wgt_reg_i`, signed, IMG_W+WGT_W bits. Also registers valid, `exp_bias` and `psum`.
- **S2 (add tree):** registers `sum = Σ p_i`, sign-extended to SUM_W = IMG_W+WGT_W+clog2(N). Valid, `exp_bias` and `psum` are carried along.
- **S3 (accumulate, finalise):**
  - Accumulator width ACC_W = SUM_W+CNT_W; it never overflows.
  - Beat counter `cnt`. `len` is the effective `acc_len`, captured on the beat that enters S1 with `cnt`==0, and held for the whole group.
  - Valid beat, not last: `acc` = (`cnt`==0 ? `sum` : `acc`+`sum`), then `cnt`++.
  - Last beat (`cnt`==`len`-1):
    - `r = (acc_new >>> exp_bias) + sext(psum)`, using `exp_bias`/`psum` from the last beat.
    - Clamp `r` to [-2^(OUT_W-1), 2^(OUT_W-1)-1]; `sat`=1 if clamped.
    - Register `out`, pulse `out_valid`, set `cnt`=0.
- **Bubbles:** `in_valid`=0 advances bubbles; `cnt` and `acc` hold.
- **`acc_clr`=1:**
  - `cnt`←0 and `acc`←0.
  - Valid beats currently in S1/S2 are discarded.
  - The input beat in the same cycle is accepted as the first beat of a new group.
  - `out`/`out_valid` are unaffected for a result already registered.
- `out` holds its last value between strobes; `sat` clears when `out_valid`=0.

## Timing
- Reset (`rst`=0, asynchronous) clears:
  - weight register
  - pipeline valids
  - `acc`, `cnt`
  - `out` (0), `out_valid` (0), `sat` (0)
- Reset mid-group discards the group; no partial result is emitted.
- Latency: a beat with `in_valid` at edge t reaches S3 at edge t+2. `out_valid` is high in the cycle after edge t+3 for the last beat of a group.
- Throughput: one beat per cycle, with no stall path.
- Back-to-back groups are allowed: the first beat of the next group may follow the last beat of the previous one immediately.
- `acc_len` change mid-group has no effect until the next group.

## Test plan
All scenarios use N=4, IMG_W=WGT_W=8, OUT_W=16.
- **Reset:** assert `rst`=0 with random inputs -> `out`=0, `out_valid`=0, `sat`=0. Release; nothing emitted without `in_valid`.
- **Basic:**
  - Load all weights 1; `img` all 15, `exp_bias`=0, `psum`=0, `acc_len`=1 -> `out`=60 exactly 3 cycles later.
  - Then `img` all 7, `exp_bias`=1, `psum`=15 -> `out`=29.
  - Weights all -1, `img` all 7 -> `out`=-28.
- **Accumulate/saturate:**
  - All lanes 127×127, `acc_len`=4, `exp_bias`=0 -> one strobe after the 4th beat, `out`=32767, `sat`=1.
  - Same with `exp_bias`=4 -> `out`=16129, `sat`=0.
- **Weight timing:** `wgt_load` (new weights 2) coincident with `in_valid` (old weights 1, `img` 15) -> `out`=60; next beat -> `out`=120.
- **Bubbles/back-to-back:** `acc_len`=3 with `in_valid` pattern 1,0,1,0,0,1,1,1,1 (`img`=1, `wgt`=1, each beat sums to 4) -> strobes with `out`=12, exactly two strobes.
- **Abort:** `acc_len`=4, two beats, then `acc_clr` with a beat -> the group restarts; an `out_valid` pulse follows only after 4 further accepted beats, counting the coincident one. A `rst` pulse mid-group produces no strobe.
